// File: rtl/dda_osc2_core.sv
// dda_osc2_core: second-order damped oscillator DDA engine. It integrates v1' = v2 and
//   v2' = -k_m*v1 - d_m*v2 with forward Euler in signed fixed point, using one shared multiplier.
// Latency: a request sampled at edge N updates v1/v2 and pulses step_valid after edge N+3.
//   In free run the engine completes one step every 3 cycles.
// Backpressure: none. A step request that arrives while busy is dropped. load aborts any step
//   in flight, and rst overrides everything.
// Ports: clk, rst (synchronous, active-high).
//   load latches ic1/ic2 into v1/v2 and captures k_m/d_m/dt_shift (dt = 2^-dt_shift).
//   step is a pulse and run is a level.
//   v1/v2 are the state, step_valid is the per-update pulse and busy means the FSM is not in IDLE.
//   step_count counts completed steps and wraps. sat is a sticky saturation flag.
// Build option DDA_OSC2_SATURATE_EN: f, v1n and v2n clamp to WIDTH bits and set sat on a clamp.
//   Without it results wrap modulo 2^WIDTH and sat stays 0.
module dda_osc2_core #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ic1,
  input  logic [WIDTH-1:0] ic2,
  input  logic [WIDTH-1:0] k_m,
  input  logic [WIDTH-1:0] d_m,
  input  logic [3:0]       dt_shift,
  input  logic             step,
  input  logic             run,
  output logic [WIDTH-1:0] v1,
  output logic [WIDTH-1:0] v2,
  output logic             step_valid,
  output logic             busy,
  output logic [CNT_W-1:0] step_count,
  output logic             sat
);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL1 = 2'd1, MUL2 = 2'd2, UPD = 2'd3} state_t;
  state_t state, state_nxt;

  logic signed [WIDTH-1:0] v1_q, v2_q, k_m_q, d_m_q, p1_q, p2_q;
  logic [3:0]              dt_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    vld_q;
  logic                    do_mul1, do_mul2, do_upd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step || run) state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = UPD;
      UPD:     state_nxt = run ? MUL1 : IDLE;
      default: state_nxt = IDLE;
    endcase
    // load aborts whatever is in flight
    if (load) state_nxt = IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = (state != IDLE);
    do_mul1 = (state == MUL1);
    do_mul2 = (state == MUL2);
    do_upd  = (state == UPD);
  end

  // ---------------- shared multiplier ----------------
  // The MUL1 cycle forms v1*k_m and the MUL2 cycle forms v2*d_m. The shift is
  // arithmetic (truncation toward -inf), and only the low WIDTH bits are kept,
  // so product overflow wraps.
  logic signed [WIDTH-1:0] mul_a, mul_b, prod_t;
  logic signed [PW-1:0]    prod, prod_sh;

  assign mul_a   = do_mul2 ? v2_q  : v1_q;
  assign mul_b   = do_mul2 ? d_m_q : k_m_q;
  assign prod    = PW'(mul_a) * PW'(mul_b);
  assign prod_sh = prod >>> FRAC;
  assign prod_t  = prod_sh[WIDTH-1:0];

  // ---------------- Euler update (uses the old v1/v2) ----------------
  // f = -p1 - p2 needs WIDTH+2 bits to stay exact.
  logic signed [WIDTH+1:0] f_full, f_use, f_sh;
  logic signed [WIDTH-1:0] v2_sh;
  logic signed [WIDTH:0]   sum1, sum2;
  logic [WIDTH-1:0]        v1_n, v2_n;

  assign f_full = -(WIDTH+2)'(p1_q) - (WIDTH+2)'(p2_q);

`ifdef DDA_OSC2_SATURATE_EN
  logic                    f_ovf, s1_ovf, s2_ovf, clamp_any;
  logic signed [WIDTH-1:0] f_w;

  always_comb begin
    f_ovf = (f_full[WIDTH+1:WIDTH-1] != 3'b000) && (f_full[WIDTH+1:WIDTH-1] != 3'b111);
    f_w   = f_full[WIDTH-1:0];
    if (f_ovf) f_w = f_full[WIDTH+1] ? MIN_W : MAX_W;
  end
  assign f_use = (WIDTH+2)'(f_w);
`else
  assign f_use = f_full;
`endif

  assign f_sh  = f_use >>> dt_q;
  assign v2_sh = v2_q >>> dt_q;
  assign sum1  = (WIDTH+1)'(v1_q) + (WIDTH+1)'(v2_sh);
  assign sum2  = (WIDTH+1)'(v2_q) + $signed(f_sh[WIDTH:0]);

`ifdef DDA_OSC2_SATURATE_EN
  always_comb begin
    s1_ovf = (sum1[WIDTH] != sum1[WIDTH-1]);
    s2_ovf = (sum2[WIDTH] != sum2[WIDTH-1]);
    v1_n   = sum1[WIDTH-1:0];
    v2_n   = sum2[WIDTH-1:0];
    if (s1_ovf) v1_n = sum1[WIDTH] ? MIN_W : MAX_W;
    if (s2_ovf) v2_n = sum2[WIDTH] ? MIN_W : MAX_W;
    clamp_any = f_ovf | s1_ovf | s2_ovf;
  end
`else
  assign v1_n = sum1[WIDTH-1:0];
  assign v2_n = sum2[WIDTH-1:0];
`endif

  // These bits are deliberately discarded. The list keeps that intent visible.
  logic unused_bits;
  assign unused_bits = ^{prod_sh[PW-1:WIDTH], f_sh[WIDTH+1], sum1[WIDTH], sum2[WIDTH],
                         MAX_W, MIN_W};

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= '0;
      v2_q  <= '0;
      k_m_q <= '0;
      d_m_q <= '0;
      dt_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (load) begin
      v1_q  <= ic1;
      v2_q  <= ic2;
      k_m_q <= k_m;
      d_m_q <= d_m;
      dt_q  <= dt_shift;
      p1_q  <= '0;
      p2_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (do_mul1) p1_q <= prod_t;
      if (do_mul2) p2_q <= prod_t;
      if (do_upd) begin
        v1_q  <= v1_n;
        v2_q  <= v2_n;
        vld_q <= 1'b1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef DDA_OSC2_SATURATE_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst)                      sat_q <= 1'b0;
    else if (load)                sat_q <= 1'b0;
    else if (do_upd && clamp_any) sat_q <= 1'b1;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign v1         = v1_q;
  assign v2         = v2_q;
  assign step_valid = vld_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_dda_osc2_core.sv
// tb_dda_osc2_core: checks dda_osc2_core against a plain-arithmetic Euler model.
// A second instance with a 4-bit step counter covers counter wrap.
module tb_dda_osc2_core;
  localparam int W    = 27;
  localparam int FRAC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, load, step, run;
  logic [W-1:0] ic1, ic2, k_m, d_m;
  logic [3:0]   dt_shift;
  logic [W-1:0] v1, v2, v1_4, v2_4;
  logic         step_valid, busy, sat, sv_4, busy_4, sat_4;
  logic [15:0]  step_count;
  logic [3:0]   cnt_4;

  dda_osc2_core #(.WIDTH(W), .FRAC(FRAC), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .load(load), .ic1(ic1), .ic2(ic2), .k_m(k_m), .d_m(d_m),
    .dt_shift(dt_shift), .step(step), .run(run), .v1(v1), .v2(v2),
    .step_valid(step_valid), .busy(busy), .step_count(step_count), .sat(sat));

  dda_osc2_core #(.WIDTH(W), .FRAC(FRAC), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .ic1(ic1), .ic2(ic2), .k_m(k_m), .d_m(d_m),
    .dt_shift(dt_shift), .step(step), .run(run), .v1(v1_4), .v2(v2_4),
    .step_valid(sv_4), .busy(busy_4), .step_count(cnt_4), .sat(sat_4));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  longint m_v1, m_v2, m_k, m_d;
  int     m_sh, m_cnt;
  bit     m_sat;

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint wrapw(input longint x);
    longint r;
    r = x & ((longint'(1) << W) - 1);
    if (r >= (longint'(1) << (W - 1))) r = r - (longint'(1) << W);
    return r;
  endfunction

  function automatic longint clampw(input longint x);
    longint hi, lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (x > hi) begin m_sat = 1'b1; return hi; end
    if (x < lo) begin m_sat = 1'b1; return lo; end
    return x;
  endfunction

  function automatic void model_load(input logic [W-1:0] a, b, k, d, input logic [3:0] sh);
    m_v1 = sx(a); m_v2 = sx(b); m_k = sx(k); m_d = sx(d); m_sh = int'(sh);
    m_cnt = 0; m_sat = 1'b0;
  endfunction

  function automatic void model_step();
    longint p1, p2, f, n1, n2;
    p1 = wrapw((m_v1 * m_k) >>> FRAC);
    p2 = wrapw((m_v2 * m_d) >>> FRAC);
    f  = -p1 - p2;
`ifdef DDA_OSC2_SATURATE_EN
    f = clampw(f);
`endif
    n1 = m_v1 + (m_v2 >>> m_sh);
    n2 = m_v2 + (f >>> m_sh);
`ifdef DDA_OSC2_SATURATE_EN
    m_v1 = clampw(n1);
    m_v2 = clampw(n2);
`else
    m_v1 = wrapw(n1);
    m_v2 = wrapw(n2);
`endif
    m_cnt++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] a, b, k, d, input logic [3:0] sh);
    ic1 = a; ic2 = b; k_m = k; d_m = d; dt_shift = sh; load = 1'b1;
    tick();
    load = 1'b0;
    model_load(a, b, k, d, sh);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (step_valid) got = 1'b1;
    end
  endtask

  function automatic logic [W-1:0] rnd_signed(input int bits);
    logic signed [W-1:0] s;
    s = W'($urandom);
    s = s >>> (W - bits);
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    load = 1'($urandom); step = 1'($urandom); run = 1'($urandom);
    ic1 = W'($urandom); ic2 = W'($urandom); k_m = W'($urandom); d_m = W'($urandom);
    dt_shift = 4'($urandom);
    tick();
    tick();
    n_cmp++; if (v1 !== '0) begin n_bad++; $display("FAIL reset_v1 got=%h exp=0", v1); end
    n_cmp++; if (v2 !== '0) begin n_bad++; $display("FAIL reset_v2 got=%h exp=0", v2); end
    n_cmp++; if (step_count !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", step_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (step_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", step_valid); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
    n_cmp++; if (cnt_4 !== '0) begin n_bad++; $display("FAIL reset_cnt4 got=%0d exp=0", cnt_4); end
    rst = 1'b0; load = 1'b0; step = 1'b0; run = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b exp=0", busy); end
  endtask

  task automatic test_single_step();
    do_load(27'h0, 27'h140000, 27'h080000, 27'h040000, 4'd9);
    step = 1'b1;
    tick();
    step = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy1 got=%b exp=1", busy); end
    tick();
    tick();
    n_cmp++; if (step_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", step_valid); end
    tick();
    model_step();
    n_cmp++; if (v1 !== 27'h000A00) begin n_bad++; $display("FAIL single_v1 got=%h exp=000a00", v1); end
    n_cmp++; if (v2 !== 27'h13FD80) begin n_bad++; $display("FAIL single_v2 got=%h exp=13fd80", v2); end
    n_cmp++; if (v2 !== W'(m_v2)) begin n_bad++; $display("FAIL single_v2_model got=%h exp=%h", v2, W'(m_v2)); end
    n_cmp++; if (step_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", step_valid); end
    n_cmp++; if (step_count !== 16'd1) begin n_bad++; $display("FAIL single_cnt got=%0d exp=1", step_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    tick();
    n_cmp++; if (step_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_pulse got=%b exp=0", step_valid); end
  endtask

  task automatic test_free_run();
    int pulses, last;
    longint v2_abs;
    do_load(27'h0, 27'h140000, 27'h080000, 27'h040000, 4'd9);
    pulses = 0; last = 1;
    run = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      if (c == 31) run = 1'b0;
      tick();
      if (step_valid) begin
        pulses++;
        model_step();
        n_cmp++; if (c - last !== 3) begin n_bad++; $display("FAIL run_spacing got=%0d exp=3", c - last); end
        n_cmp++; if (v1 !== W'(m_v1)) begin n_bad++; $display("FAIL run_v1 step=%0d got=%h exp=%h", pulses, v1, W'(m_v1)); end
        n_cmp++; if (v2 !== W'(m_v2)) begin n_bad++; $display("FAIL run_v2 step=%0d got=%h exp=%h", pulses, v2, W'(m_v2)); end
        last = c;
      end
    end
    n_cmp++; if (pulses !== 10) begin n_bad++; $display("FAIL run_pulses got=%0d exp=10", pulses); end
    n_cmp++; if (step_count !== 16'd10) begin n_bad++; $display("FAIL run_cnt got=%0d exp=10", step_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run_busy got=%b exp=0", busy); end
    v2_abs = sx(v2);
    if (v2_abs < 0) v2_abs = -v2_abs;
    n_cmp++; if (!(v2_abs < 64'sh140000)) begin n_bad++; $display("FAIL run_decay got=%h exp<140000", v2); end
  endtask

  task automatic test_abort();
    int pulses;
    do_load(27'h0, 27'h140000, 27'h080000, 27'h040000, 4'd9);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_mul2 got=%b exp=1", busy); end
    do_load(27'h100000, 27'h0, 27'h080000, 27'h040000, 4'd9);
    n_cmp++; if (v1 !== 27'h100000) begin n_bad++; $display("FAIL abort_v1 got=%h exp=100000", v1); end
    n_cmp++; if (v2 !== 27'h0) begin n_bad++; $display("FAIL abort_v2 got=%h exp=0", v2); end
    n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL abort_cnt got=%0d exp=0", step_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (step_valid) pulses++;
      tick();
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_valid got=%0d exp=0", pulses); end
  endtask

  task automatic test_step_ignored();
    int pulses;
    do_load(rnd_signed(22), rnd_signed(22), rnd_signed(21), rnd_signed(21), 4'($urandom_range(0, 15)));
    step = 1'b1;
    tick(); tick(); tick();
    step = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (step_valid) begin
        pulses++;
        model_step();
        n_cmp++; if (v1 !== W'(m_v1)) begin n_bad++; $display("FAIL ignore_v1 got=%h exp=%h", v1, W'(m_v1)); end
        n_cmp++; if (v2 !== W'(m_v2)) begin n_bad++; $display("FAIL ignore_v2 got=%h exp=%h", v2, W'(m_v2)); end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (step_count !== 16'd1) begin n_bad++; $display("FAIL ignore_cnt got=%0d exp=1", step_count); end
  endtask

  task automatic test_overflow();
    bit got;
    logic [W-1:0] exp_v1;
    logic         exp_sat;
`ifdef DDA_OSC2_SATURATE_EN
    exp_v1 = 27'h3FFFFFF; exp_sat = 1'b1;
`else
    exp_v1 = 27'h40FFF00; exp_sat = 1'b0;
`endif
    do_load(27'h3FFFF00, 27'h100000, 27'h0, 27'h0, 4'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_valid(12, got);
    model_step();
    n_cmp++; if (!got) begin n_bad++; $display("FAIL ovf_timeout got=no_valid exp=valid"); end
    n_cmp++; if (v1 !== exp_v1) begin n_bad++; $display("FAIL ovf_v1 got=%h exp=%h", v1, exp_v1); end
    n_cmp++; if (v2 !== 27'h100000) begin n_bad++; $display("FAIL ovf_v2 got=%h exp=100000", v2); end
    n_cmp++; if (sat !== exp_sat) begin n_bad++; $display("FAIL ovf_sat got=%b exp=%b", sat, exp_sat); end
    n_cmp++; if (sat !== m_sat) begin n_bad++; $display("FAIL ovf_sat_model got=%b exp=%b", sat, m_sat); end
    tick();
    n_cmp++; if (sat !== exp_sat) begin n_bad++; $display("FAIL ovf_sat_sticky got=%b exp=%b", sat, exp_sat); end
    do_load(27'h0, 27'h0, 27'h0, 27'h0, 4'd0);
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL ovf_sat_clear got=%b exp=0", sat); end
  endtask

  task automatic test_cnt_wrap();
    int pulses, last, c;
    do_load(rnd_signed(21), rnd_signed(21), rnd_signed(20), rnd_signed(20), 4'd6);
    pulses = 0; last = 1; c = 0;
    run = 1'b1;
    while (pulses < 18 && c < 80) begin
      c++;
      tick();
      if (step_valid) begin
        pulses++;
        model_step();
        n_cmp++; if (c - last !== 3) begin n_bad++; $display("FAIL wrap_spacing got=%0d exp=3", c - last); end
        n_cmp++; if (cnt_4 !== 4'(pulses)) begin n_bad++; $display("FAIL wrap_cnt4 got=%0d exp=%0d", cnt_4, 4'(pulses)); end
        n_cmp++; if (v1_4 !== W'(m_v1)) begin n_bad++; $display("FAIL wrap_v1 got=%h exp=%h", v1_4, W'(m_v1)); end
        if (pulses == 16) begin
          n_cmp++; if (cnt_4 !== 4'd0) begin n_bad++; $display("FAIL wrap_zero got=%0d exp=0", cnt_4); end
          n_cmp++; if (step_count !== 16'd16) begin n_bad++; $display("FAIL wrap_cnt16 got=%0d exp=16", step_count); end
        end
        last = c;
      end
    end
    run = 1'b0;
    n_cmp++; if (pulses !== 18) begin n_bad++; $display("FAIL wrap_timeout got=%0d exp=18", pulses); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    bit got;
    int n;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(W'($urandom), W'($urandom), rnd_signed(24), rnd_signed(24), 4'($urandom_range(0, 15)));
      else
        do_load(rnd_signed(23), rnd_signed(23), rnd_signed(23), rnd_signed(22), 4'($urandom_range(0, 15)));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) begin
        for (int s = 0; s < n; s++) begin
          step = 1'b1;
          tick();
          step = 1'($urandom);
          wait_valid(12, got);
          step = 1'b0;
          model_step();
          n_cmp++; if (!got) begin n_bad++; $display("FAIL rnd_step_timeout it=%0d got=no_valid exp=valid", it); end
          n_cmp++; if (v1 !== W'(m_v1)) begin n_bad++; $display("FAIL rnd_v1 it=%0d got=%h exp=%h", it, v1, W'(m_v1)); end
          n_cmp++; if (v2 !== W'(m_v2)) begin n_bad++; $display("FAIL rnd_v2 it=%0d got=%h exp=%h", it, v2, W'(m_v2)); end
          for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
      end else begin
        run = 1'b1;
        tick();
        if (n == 1) run = 1'b0;
        for (int s = 1; s <= n; s++) begin
          wait_valid(12, got);
          if (s == n - 1) run = 1'b0;
          model_step();
          n_cmp++; if (!got) begin n_bad++; $display("FAIL rnd_run_timeout it=%0d got=no_valid exp=valid", it); end
          n_cmp++; if (v1 !== W'(m_v1)) begin n_bad++; $display("FAIL rnd_run_v1 it=%0d got=%h exp=%h", it, v1, W'(m_v1)); end
          n_cmp++; if (v2 !== W'(m_v2)) begin n_bad++; $display("FAIL rnd_run_v2 it=%0d got=%h exp=%h", it, v2, W'(m_v2)); end
        end
        run = 1'b0;
        tick();
      end
      n_cmp++; if (step_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, step_count, m_cnt); end
      n_cmp++; if (sat !== m_sat) begin n_bad++; $display("FAIL rnd_sat it=%0d got=%b exp=%b", it, sat, m_sat); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_busy it=%0d got=%b exp=0", it, busy); end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; step = 1'b0; run = 1'b0;
    ic1 = '0; ic2 = '0; k_m = '0; d_m = '0; dt_shift = '0;
    model_load('0, '0, '0, '0, '0);
    test_reset();
    test_single_step();
    test_free_run();
    test_abort();
    test_step_ignored();
    test_overflow();
    test_cnt_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
